bit_packer: RTL and testbench

Parametrised streaming concatenation engine. Accepts variable-length bit fragments, optionally replicated N times, and appends each one at the LSB side of a running accumulator, so the packed stream follows the `{older, newer}` concatenation order. Emits fixed-width output words through a valid/ready handshake. A flush input closes a packet by emitting the remaining partial word, MSB-justified. It sits between field generators and word-oriented sinks such as FIFOs, bus adapters and serializers.

---
 rtl/bit_packer.sv | 209 ++++++++++++++++++++
 tb/tb_bit_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_packer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_packer
//  Description : Streaming concatenation engine. Variable-length fragments,
//                optionally replicated, are appended at the LSB side of a
//                running accumulator (oldest bit ends up at the MSB of the
//                emitted word). Fixed-width words leave through a valid/ready
//                output register; a flush closes the packet by emitting the
//                remaining partial word MSB-justified.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk    in   clock, rising edge
//    i_rst    in   asynchronous reset, active low
//    i_valid  in   fragment valid
//    i_ready  out  fragment accepted when i_valid && i_ready
//    i_data   in   fragment bits, only [i_len-1:0] are used
//    i_len    in   fragment length, 1..IN_WIDTH
//    i_rep    in   replication count, 1..REP_MAX
//    i_flush  in   fragment closes the packet
//    o_valid  out  output word valid
//    o_ready  in   sink ready
//    o_data   out  packed word, oldest bit at the MSB
//    o_bits   out  meaningful bits in o_data
//    o_last   out  final word of a packet
//    o_err    out  sticky illegal-fragment flag
// ============================================================================
module bit_packer #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32,
    parameter int REP_MAX   = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_valid,
    output logic                               i_ready,
    input  logic [IN_WIDTH-1:0]                i_data,
    input  logic [$clog2(IN_WIDTH+1)-1:0]      i_len,
    input  logic [$clog2(REP_MAX+1)-1:0]       i_rep,
    input  logic                               i_flush,
    output logic                               o_valid,
    input  logic                               o_ready,
    output logic [OUT_WIDTH-1:0]               o_data,
    output logic [$clog2(OUT_WIDTH+1)-1:0]     o_bits,
    output logic                               o_last,
    output logic                               o_err
);

    localparam int LEN_W  = $clog2(IN_WIDTH + 1);
    localparam int REP_W  = $clog2(REP_MAX + 1);
    localparam int BITS_W = $clog2(OUT_WIDTH + 1);
    localparam int ACC_W  = 2 * OUT_WIDTH;
    // Total after an append is always below 2*OUT_WIDTH.
    localparam int CNT_W  = $clog2(2 * OUT_WIDTH);
    // Wide enough for any len*rep product, legal or not.
    localparam int EL_W   = LEN_W + REP_W;

    typedef enum logic [0:0] {
        ACCUM      = 1'b0,
        FLUSH_PEND = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [ACC_W-1:0]     acc, acc_next;
    logic [CNT_W-1:0]     cnt, cnt_next;

    logic [EL_W-1:0]      eff_len;
    logic                 legal;
    logic [IN_WIDTH-1:0]  data_masked;
    logic [ACC_W-1:0]     frag;
    logic [ACC_W-1:0]     acc_shifted;
    logic [CNT_W-1:0]     tot;
    logic                 slot_free;

    logic                 load;
    logic [OUT_WIDTH-1:0] load_data;
    logic [BITS_W-1:0]    load_bits;
    logic                 load_last;
    logic                 err_set;

    // ------------------------------------------------------------------
    // Fragment construction: mask to i_len bits, then replicate i_rep times.
    // All copies are identical, so the placement order of the copies does
    // not matter.
    // ------------------------------------------------------------------
    always_comb begin
        eff_len = EL_W'(i_len) * EL_W'(i_rep);
        legal   = (i_len != '0) && (i_len <= LEN_W'(IN_WIDTH)) &&
                  (i_rep != '0) && (i_rep <= REP_W'(REP_MAX)) &&
                  (eff_len <= EL_W'(OUT_WIDTH));

        data_masked = '0;
        for (int b = 0; b < IN_WIDTH; b++) begin
            if (b < int'(i_len)) begin
                data_masked[b] = i_data[b];
            end
        end

        frag = '0;
        for (int r = 0; r < REP_MAX; r++) begin
            if (r < int'(i_rep)) begin
                frag = frag | (ACC_W'(data_masked) << (r * int'(i_len)));
            end
        end

        // Bits above the valid count are don't-care; every extraction
        // below selects by count, so they never reach o_data.
        acc_shifted = (acc << eff_len) | frag;
        tot         = cnt + CNT_W'(eff_len);
    end

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        load       = 1'b0;
        load_data  = '0;
        load_bits  = '0;
        load_last  = 1'b0;
        err_set    = 1'b0;
        i_ready    = 1'b0;
        slot_free  = !o_valid || o_ready;

        case (state)
            ACCUM: begin
                i_ready = slot_free;
                if (i_valid && slot_free) begin
                    if (!legal) begin
                        // Consumed but otherwise ignored, flush included.
                        err_set = 1'b1;
                    end else begin
                        acc_next = acc_shifted;
                        if (tot >= CNT_W'(OUT_WIDTH)) begin
                            load      = 1'b1;
                            load_data = OUT_WIDTH'(acc_shifted >> (tot - CNT_W'(OUT_WIDTH)));
                            load_bits = BITS_W'(OUT_WIDTH);
                            cnt_next  = tot - CNT_W'(OUT_WIDTH);
                            load_last = i_flush && (tot == CNT_W'(OUT_WIDTH));
                            // Remainder needs a second word once the slot frees.
                            if (i_flush && (tot > CNT_W'(OUT_WIDTH))) begin
                                state_next = FLUSH_PEND;
                            end
                        end else begin
                            cnt_next = tot;
                            if (i_flush) begin
                                load      = 1'b1;
                                load_data = OUT_WIDTH'(acc_shifted << (CNT_W'(OUT_WIDTH) - tot));
                                load_bits = BITS_W'(tot);
                                load_last = 1'b1;
                                cnt_next  = '0;
                            end
                        end
                    end
                end
            end

            FLUSH_PEND: begin
                if (slot_free) begin
                    load       = 1'b1;
                    load_data  = OUT_WIDTH'(acc << (CNT_W'(OUT_WIDTH) - cnt));
                    load_bits  = BITS_W'(cnt);
                    load_last  = 1'b1;
                    cnt_next   = '0;
                    state_next = ACCUM;
                end
            end

            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, accumulator and output register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_bits  <= '0;
            o_last  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            if (err_set) begin
                o_err <= 1'b1;
            end
            if (load) begin
                o_valid <= 1'b1;
                o_data  <= load_data;
                o_bits  <= load_bits;
                o_last  <= load_last;
            end else if (o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_packer
//  Description : Self-checking bench for bit_packer (IN 8 / OUT 32 / REP 4).
//                A table of single-cycle fragments with expected outputs,
//                followed by hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_packer;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        i_ready;
    logic [7:0]  i_data;
    logic [3:0]  i_len;
    logic [2:0]  i_rep;
    logic        i_flush;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic [5:0]  o_bits;
    logic        o_last;
    logic        o_err;

    int n_pass  = 0;
    int n_total = 0;

    bit_packer #(
        .IN_WIDTH  (8),
        .OUT_WIDTH (32),
        .REP_MAX   (4)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_len   (i_len),
        .i_rep   (i_rep),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_bits  (o_bits),
        .o_last  (o_last),
        .o_err   (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  data;
        logic [3:0]  len;
        logic [2:0]  rep;
        logic        flush;
        logic        ev;
        logic [31:0] ed;
        logic [5:0]  eb;
        logic        el;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] data, input logic [3:0] len,
                                input logic [2:0] rep, input logic flush,
                                input logic ev, input logic [31:0] ed,
                                input logic [5:0] eb, input logic el,
                                input logic ee);
        vec_t v;
        v.data = data; v.len = len; v.rep = rep; v.flush = flush;
        v.ev = ev; v.ed = ed; v.eb = eb; v.el = el; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Return one time unit after the next rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] data, input logic [3:0] len,
                        input logic [2:0] rep, input logic flush);
        i_data  = data;
        i_len   = len;
        i_rep   = rep;
        i_flush = flush;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_flush = 1'b0;
        o_ready = 1'b1;
        i_rst   = 1'b0;
        tick();
        tick();
        i_rst   = 1'b1;
        #1;
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_len   = 4'd1;
        i_rep   = 3'd1;
        i_flush = 1'b0;
        o_ready = 1'b1;
        #2;
        do_reset();

        // ---------------- reset state ----------------
        chk("reset o_valid", 64'(o_valid), 64'(0));
        chk("reset o_data",  64'(o_data),  64'(0));
        chk("reset o_bits",  64'(o_bits),  64'(0));
        chk("reset o_last",  64'(o_last),  64'(0));
        chk("reset o_err",   64'(o_err),   64'(0));
        chk("reset i_ready", 64'(i_ready), 64'(1));

        // ---------------- table-driven vectors ----------------
        // byte packing
        vecs.push_back(mk(8'hDE, 4'd8, 3'd1, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0));
        vecs.push_back(mk(8'hAD, 4'd8, 3'd1, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0));
        vecs.push_back(mk(8'hBE, 4'd8, 3'd1, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0));
        vecs.push_back(mk(8'hEF, 4'd8, 3'd1, 1'b0, 1'b1, 32'hDEADBEEF, 6'd32, 1'b0, 1'b0));
        // replication
        vecs.push_back(mk(8'h0A, 4'd4, 3'd4, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0));
        vecs.push_back(mk(8'h0A, 4'd4, 3'd4, 1'b0, 1'b1, 32'hAAAAAAAA, 6'd32, 1'b0, 1'b0));
        vecs.push_back(mk(8'h01, 4'd1, 3'd3, 1'b1, 1'b1, 32'hE0000000, 6'd3,  1'b1, 1'b0));
        // straddle: five 7-bit all-ones fragments, then a 1-bit zero flush
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(8'h7F, 4'd7, 3'd1, 1'b0, 1'b0, 32'h0,    6'd0,  1'b0, 1'b0));
        vecs.push_back(mk(8'h7F, 4'd7, 3'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 6'd32, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 4'd1, 3'd1, 1'b1, 1'b1, 32'hE0000000, 6'd4,  1'b1, 1'b0));
        // L = 32 is legal
        vecs.push_back(mk(8'hA5, 4'd8, 3'd4, 1'b0, 1'b1, 32'hA5A5A5A5, 6'd32, 1'b0, 1'b0));
        // illegal len 0 with flush: consumed, no output, count kept
        vecs.push_back(mk(8'hAB, 4'd8, 3'd1, 1'b0, 1'b0, 32'h0,        6'd0,  1'b0, 1'b0));
        vecs.push_back(mk(8'hFF, 4'd0, 3'd1, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b1));
        vecs.push_back(mk(8'hCD, 4'd8, 3'd1, 1'b1, 1'b1, 32'hABCD0000, 6'd16, 1'b1, 1'b1));
        // rep 0 and rep 5 are illegal
        vecs.push_back(mk(8'hFF, 4'd3, 3'd0, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b1));
        vecs.push_back(mk(8'h01, 4'd1, 3'd5, 1'b1, 1'b0, 32'h0,        6'd0,  1'b0, 1'b1));
        // upper data bits beyond len are ignored: 101 x2 -> 101101
        vecs.push_back(mk(8'hF5, 4'd3, 3'd2, 1'b1, 1'b1, 32'hB4000000, 6'd6,  1'b1, 1'b1));

        for (int k = 0; k < vecs.size(); k++) begin
            chk($sformatf("vec%0d i_ready", k), 64'(i_ready), 64'(1));
            send(vecs[k].data, vecs[k].len, vecs[k].rep, vecs[k].flush);
            chk($sformatf("vec%0d o_valid", k), 64'(o_valid), 64'(vecs[k].ev));
            chk($sformatf("vec%0d o_err", k),   64'(o_err),   64'(vecs[k].ee));
            if (vecs[k].ev) begin
                chk($sformatf("vec%0d o_data", k), 64'(o_data), 64'(vecs[k].ed));
                chk($sformatf("vec%0d o_bits", k), 64'(o_bits), 64'(vecs[k].eb));
                chk($sformatf("vec%0d o_last", k), 64'(o_last), 64'(vecs[k].el));
            end
        end

        // ---------------- flush overflow ----------------
        do_reset();
        for (int i = 0; i < 7; i++) send(8'h0F, 4'd4, 3'd1, 1'b0);
        chk("ovf no early word", 64'(o_valid), 64'(0));
        send(8'h5A, 4'd8, 3'd1, 1'b1);
        chk("ovf w1 valid",   64'(o_valid), 64'(1));
        chk("ovf w1 data",    64'(o_data),  64'(32'hFFFFFFF5));
        chk("ovf w1 bits",    64'(o_bits),  64'(32));
        chk("ovf w1 last",    64'(o_last),  64'(0));
        chk("ovf pend ready", 64'(i_ready), 64'(0));
        tick();
        chk("ovf w2 valid",   64'(o_valid), 64'(1));
        chk("ovf w2 data",    64'(o_data),  64'(32'hA0000000));
        chk("ovf w2 bits",    64'(o_bits),  64'(4));
        chk("ovf w2 last",    64'(o_last),  64'(1));
        chk("ovf ready back", 64'(i_ready), 64'(1));
        tick();
        chk("ovf drained",    64'(o_valid), 64'(0));

        // ---------------- backpressure ----------------
        o_ready = 1'b0;
        send(8'h11, 4'd8, 3'd1, 1'b0);
        send(8'h22, 4'd8, 3'd1, 1'b0);
        send(8'h33, 4'd8, 3'd1, 1'b0);
        send(8'h44, 4'd8, 3'd1, 1'b0);
        // Offer a fragment that must not be taken while the word is held.
        i_data = 8'h55; i_len = 4'd8; i_rep = 3'd1; i_flush = 1'b1; i_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp c%0d valid", c), 64'(o_valid), 64'(1));
            chk($sformatf("bp c%0d data", c),  64'(o_data),  64'(32'h11223344));
            chk($sformatf("bp c%0d ready", c), 64'(i_ready), 64'(0));
            tick();
        end
        chk("bp hold bits", 64'(o_bits), 64'(32));
        chk("bp hold last", 64'(o_last), 64'(0));
        o_ready = 1'b1;
        #1;
        chk("bp release ready", 64'(i_ready), 64'(1));
        tick();
        i_valid = 1'b0; i_flush = 1'b0;
        chk("bp next valid", 64'(o_valid), 64'(1));
        chk("bp next data",  64'(o_data),  64'(32'h55000000));
        chk("bp next bits",  64'(o_bits),  64'(8));
        chk("bp next last",  64'(o_last),  64'(1));
        tick();
        chk("bp drained",    64'(o_valid), 64'(0));

        // ---------------- len 9 forced ----------------
        do_reset();
        chk("len9 err before", 64'(o_err), 64'(0));
        send(8'h01, 4'd9, 3'd1, 1'b1);
        chk("len9 err",   64'(o_err),   64'(1));
        chk("len9 valid", 64'(o_valid), 64'(0));

        // ---------------- asynchronous reset mid-packet ----------------
        do_reset();
        send(8'h00, 4'd0, 3'd1, 1'b0);
        send(8'h11, 4'd8, 3'd1, 1'b0);
        send(8'h22, 4'd8, 3'd1, 1'b0);
        send(8'h33, 4'd8, 3'd1, 1'b0);
        send(8'h1F, 4'd5, 3'd4, 1'b0);
        chk("ar pre valid", 64'(o_valid), 64'(1));
        chk("ar pre data",  64'(o_data),  64'(32'h112233FF));
        chk("ar pre err",   64'(o_err),   64'(1));
        o_ready = 1'b0;
        tick();
        i_rst = 1'b0;
        #2;
        chk("ar o_valid", 64'(o_valid), 64'(0));
        chk("ar o_data",  64'(o_data),  64'(0));
        chk("ar o_bits",  64'(o_bits),  64'(0));
        chk("ar o_last",  64'(o_last),  64'(0));
        chk("ar o_err",   64'(o_err),   64'(0));
        tick();
        i_rst   = 1'b1;
        o_ready = 1'b1;
        #1;
        send(8'hDE, 4'd8, 3'd1, 1'b0);
        send(8'hAD, 4'd8, 3'd1, 1'b0);
        send(8'hBE, 4'd8, 3'd1, 1'b0);
        chk("ar post early", 64'(o_valid), 64'(0));
        send(8'hEF, 4'd8, 3'd1, 1'b0);
        chk("ar post valid", 64'(o_valid), 64'(1));
        chk("ar post data",  64'(o_data),  64'(32'hDEADBEEF));
        chk("ar post bits",  64'(o_bits),  64'(32));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
